// File: rtl/str_ofs_conv_sched.sv
// Round-robin scheduler sharing one byte-offset stream converter among CH_NUM
// DMA channels. A granted channel configures the converter (s_ofs/m_ofs from
// the address low bits), streams into it until tlast, and keeps the grant
// until the converter reports its own output tlast.
module str_ofs_conv_sched #(
   parameter  int DATA_WIDTH = 512,
   parameter  int BYTE_WIDTH = 8,
   parameter  int CH_NUM     = 4,
   parameter  int ADDR_WIDTH = 32,
   localparam int KEEP_W     = DATA_WIDTH / BYTE_WIDTH,
   localparam int OFS_W      = $clog2(KEEP_W)
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [CH_NUM-1:0]            i_cmd_vld,
   output logic [CH_NUM-1:0]            o_cmd_rdy,
   input  logic [CH_NUM*ADDR_WIDTH-1:0] i_cmd_saddr,
   input  logic [CH_NUM*ADDR_WIDTH-1:0] i_cmd_daddr,
   input  logic [CH_NUM*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [CH_NUM*KEEP_W-1:0]     s_axis_tkeep,
   input  logic [CH_NUM-1:0]            s_axis_tlast,
   input  logic [CH_NUM-1:0]            s_axis_tvld,
   output logic [CH_NUM-1:0]            s_axis_trdy,
   output logic                         o_conv_vld,
   input  logic                         i_conv_rdy,
   output logic [OFS_W-1:0]             o_conv_s_ofs,
   output logic [OFS_W-1:0]             o_conv_m_ofs,
   output logic [DATA_WIDTH-1:0]        m_axis_tdata,
   output logic [KEEP_W-1:0]            m_axis_tkeep,
   output logic                         m_axis_tlast,
   output logic                         m_axis_tvld,
   input  logic                         m_axis_trdy,
   input  logic                         i_out_last,
   output logic [CH_NUM-1:0]            o_grant,
   output logic [CH_NUM-1:0]            o_done
);

   localparam int PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CFG,
      ST_STRM,
      ST_DRAIN
   } state_t;

   state_t             state_q, state_d;
   logic [CH_NUM-1:0]  grant_q, grant_d;
   // ptr_q is both the round-robin pointer and the granted channel index
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic               conv_vld_q, conv_vld_d;
   logic [OFS_W-1:0]   s_ofs_q, s_ofs_d;
   logic [OFS_W-1:0]   m_ofs_q, m_ofs_d;
   logic [CH_NUM-1:0]  done_q, done_d;
   logic               seen_q, seen_d;

   logic               req_found;
   logic [PTR_W-1:0]   req_idx;
   logic [PTR_W-1:0]   cand;
   logic               beat_last;

   // round-robin search: first requesting channel after the last grant, with wrap
   always_comb begin
      req_found = 1'b0;
      req_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= CH_NUM; i++) begin
         cand = PTR_W'((int'(ptr_q) + i) % CH_NUM);
         if (!req_found && i_cmd_vld[cand]) begin
            req_found = 1'b1;
            req_idx   = cand;
         end
      end
   end

   // zero-latency stream mux from the granted channel; idle outputs forced low
   always_comb begin
      m_axis_tdata = '0;
      m_axis_tkeep = '0;
      m_axis_tlast = 1'b0;
      m_axis_tvld  = 1'b0;
      s_axis_trdy  = '0;
      if (state_q == ST_STRM) begin
         m_axis_tdata       = s_axis_tdata[int'(ptr_q)*DATA_WIDTH +: DATA_WIDTH];
         m_axis_tkeep       = s_axis_tkeep[int'(ptr_q)*KEEP_W +: KEEP_W];
         m_axis_tlast       = s_axis_tlast[ptr_q];
         m_axis_tvld        = s_axis_tvld[ptr_q];
         s_axis_trdy[ptr_q] = m_axis_trdy;
      end
      beat_last = m_axis_tvld & m_axis_trdy & m_axis_tlast;
   end

   // next-state logic, command accept and completion
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      conv_vld_d = conv_vld_q;
      s_ofs_d    = s_ofs_q;
      m_ofs_d    = m_ofs_q;
      done_d     = '0;
      seen_d     = seen_q;
      o_cmd_rdy  = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_found) begin
               o_cmd_rdy[req_idx] = 1'b1;
               grant_d            = '0;
               grant_d[req_idx]   = 1'b1;
               ptr_d              = req_idx;
               s_ofs_d            = i_cmd_saddr[int'(req_idx)*ADDR_WIDTH +: OFS_W];
               m_ofs_d            = i_cmd_daddr[int'(req_idx)*ADDR_WIDTH +: OFS_W];
               conv_vld_d         = 1'b1;
               seen_d             = 1'b0;
               state_d            = ST_CFG;
            end
         end
         ST_CFG: begin
            if (i_out_last) seen_d = 1'b1;
            if (i_conv_rdy) begin
               conv_vld_d = 1'b0;
               state_d    = ST_STRM;
            end
         end
         ST_STRM: begin
            if (beat_last) begin
               // converter already finished its output: complete without draining
               if (seen_q || i_out_last) begin
                  done_d  = grant_q;
                  grant_d = '0;
                  seen_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DRAIN;
               end
            end else if (i_out_last) begin
               seen_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (i_out_last) begin
               done_d  = grant_q;
               grant_d = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state registers; reset abandons any transfer in flight
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         ptr_q      <= PTR_W'(CH_NUM - 1);
         conv_vld_q <= 1'b0;
         s_ofs_q    <= '0;
         m_ofs_q    <= '0;
         done_q     <= '0;
         seen_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         conv_vld_q <= conv_vld_d;
         s_ofs_q    <= s_ofs_d;
         m_ofs_q    <= m_ofs_d;
         done_q     <= done_d;
         seen_q     <= seen_d;
      end
   end

   assign o_grant      = grant_q;
   assign o_done       = done_q;
   assign o_conv_vld   = conv_vld_q;
   assign o_conv_s_ofs = s_ofs_q;
   assign o_conv_m_ofs = m_ofs_q;

endmodule

// File: tb/tb_str_ofs_conv_sched.sv
// Bench for str_ofs_conv_sched: directed scenarios plus a randomized run
// against a transaction-level scheduler model.
module tb_str_ofs_conv_sched;

   localparam int DW = 512;
   localparam int BW = 8;
   localparam int CH = 4;
   localparam int AW = 32;
   localparam int KW = DW / BW;
   localparam int OW = 6;

   logic            clk = 1'b0;
   logic            rst;
   logic [CH-1:0]   cmd_vld, cmd_rdy;
   logic [CH*AW-1:0] saddr, daddr;
   logic [CH*DW-1:0] s_tdata;
   logic [CH*KW-1:0] s_tkeep;
   logic [CH-1:0]   s_tlast, s_tvld, s_trdy;
   logic            conv_vld, conv_rdy;
   logic [OW-1:0]   s_ofs, m_ofs;
   logic [DW-1:0]   m_tdata;
   logic [KW-1:0]   m_tkeep;
   logic            m_tlast, m_tvld, m_trdy, out_last;
   logic [CH-1:0]   grant, done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   str_ofs_conv_sched #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .CH_NUM(CH), .ADDR_WIDTH(AW)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_cmd_vld(cmd_vld), .o_cmd_rdy(cmd_rdy),
      .i_cmd_saddr(saddr), .i_cmd_daddr(daddr),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
      .s_axis_tvld(s_tvld), .s_axis_trdy(s_trdy),
      .o_conv_vld(conv_vld), .i_conv_rdy(conv_rdy),
      .o_conv_s_ofs(s_ofs), .o_conv_m_ofs(m_ofs),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
      .m_axis_tvld(m_tvld), .m_axis_trdy(m_trdy),
      .i_out_last(out_last), .o_grant(grant), .o_done(done)
   );

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] r;
      for (int j = 0; j < DW/32; j++) r[j*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [KW-1:0] rnd_keep();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [CH-1:0] oh(input int k);
      logic [CH-1:0] r;
      r    = '0;
      r[k] = 1'b1;
      return r;
   endfunction

   // first requesting channel after 'from', wrapping; -1 if none
   function automatic int pick(input logic [CH-1:0] m, input int from);
      for (int i = 1; i <= CH; i++)
         if (m[(from + i) % CH]) return (from + i) % CH;
      return -1;
   endfunction

   task automatic set_beat(input int ch, input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic l, input logic v);
      s_tdata[ch*DW +: DW] = d;
      s_tkeep[ch*KW +: KW] = k;
      s_tlast[ch]          = l;
      s_tvld[ch]           = v;
   endtask

   task automatic clr_inputs();
      cmd_vld  = '0;
      saddr    = '0;
      daddr    = '0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tlast  = '0;
      s_tvld   = '0;
      conv_rdy = 1'b0;
      m_trdy   = 1'b0;
      out_last = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clr_inputs();
      tick();
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      clr_inputs();
      rst = 1'b1;
      for (int c = 0; c < CH; c++) set_beat(c, rnd_data(), rnd_keep(), 1'b1, 1'b1);
      m_trdy = 1'b1; conv_rdy = 1'b1; out_last = 1'b1;
      tick();
      tick();
      total++; if (grant !== '0) begin bad++; $display("FAIL reset_grant got=%b want=0", grant); end
      total++; if (conv_vld !== 1'b0) begin bad++; $display("FAIL reset_conv_vld got=%b want=0", conv_vld); end
      total++; if (s_ofs !== '0 || m_ofs !== '0) begin bad++; $display("FAIL reset_ofs got=%h/%h want=0/0", s_ofs, m_ofs); end
      total++; if (done !== '0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (cmd_rdy !== '0) begin bad++; $display("FAIL reset_cmd_rdy got=%b want=0", cmd_rdy); end
      total++; if (s_trdy !== '0) begin bad++; $display("FAIL reset_s_trdy got=%b want=0", s_trdy); end
      total++; if (m_tvld !== 1'b0 || m_tlast !== 1'b0) begin bad++; $display("FAIL reset_m_ctl got=%b%b want=00", m_tvld, m_tlast); end
      total++; if (m_tdata !== '0 || m_tkeep !== '0) begin bad++; $display("FAIL reset_m_data got nonzero want=0"); end
      rst = 1'b0;
      clr_inputs();
   endtask

   task automatic test_ch2_cmd();
      logic [DW-1:0] d;
      do_reset();
      saddr = {$urandom, $urandom, $urandom, $urandom};
      daddr = {$urandom, $urandom, $urandom, $urandom};
      saddr[2*AW +: AW] = 32'h0000_1005;
      daddr[2*AW +: AW] = 32'h0000_2030;
      cmd_vld = 4'b0100;
      #1;
      total++; if (cmd_rdy !== 4'b0100) begin bad++; $display("FAIL ch2_cmd_rdy got=%b want=0100", cmd_rdy); end
      tick();
      cmd_vld = '0;
      total++; if (conv_vld !== 1'b1) begin bad++; $display("FAIL ch2_conv_vld got=%b want=1", conv_vld); end
      total++; if (s_ofs !== 6'd5) begin bad++; $display("FAIL ch2_s_ofs got=%h want=05", s_ofs); end
      total++; if (m_ofs !== 6'h30) begin bad++; $display("FAIL ch2_m_ofs got=%h want=30", m_ofs); end
      total++; if (grant !== 4'b0100) begin bad++; $display("FAIL ch2_grant got=%b want=0100", grant); end
      conv_rdy = 1'b1;
      tick();
      conv_rdy = 1'b0;
      d = rnd_data();
      set_beat(2, d, '1, 1'b1, 1'b1);
      m_trdy = 1'b1;
      #1;
      total++; if (m_tvld !== 1'b1 || m_tlast !== 1'b1 || m_tdata !== d) begin bad++; $display("FAIL ch2_single_beat got vld=%b last=%b want 1/1 with data", m_tvld, m_tlast); end
      tick();
      set_beat(2, '0, '0, 1'b0, 1'b0);
      total++; if (grant !== 4'b0100 || done !== '0) begin bad++; $display("FAIL ch2_drain got grant=%b done=%b want=0100/0000", grant, done); end
      out_last = 1'b1;
      tick();
      out_last = 1'b0;
      total++; if (done !== 4'b0100 || grant !== '0) begin bad++; $display("FAIL ch2_done got done=%b grant=%b want=0100/0000", done, grant); end
      tick();
      total++; if (done !== '0) begin bad++; $display("FAIL ch2_done_pulse got=%b want=0", done); end
   endtask

   task automatic test_cfg_stall();
      logic [OW-1:0] se, me;
      do_reset();
      saddr = {$urandom, $urandom, $urandom, $urandom};
      daddr = {$urandom, $urandom, $urandom, $urandom};
      se = saddr[0 +: OW];
      me = daddr[0 +: OW];
      cmd_vld = 4'b0001;
      tick();
      cmd_vld = '0;
      saddr   = ~saddr;
      daddr   = ~daddr;
      set_beat(0, rnd_data(), '1, 1'b0, 1'b1);
      m_trdy = 1'b1;
      for (int c = 0; c < 5; c++) begin
         total++; if (conv_vld !== 1'b1 || s_ofs !== se || m_ofs !== me) begin bad++; $display("FAIL cfg_hold c=%0d got vld=%b ofs=%h/%h want 1 %h/%h", c, conv_vld, s_ofs, m_ofs, se, me); end
         #1;
         total++; if (m_tvld !== 1'b0) begin bad++; $display("FAIL cfg_no_stream c=%0d got=%b want=0", c, m_tvld); end
         tick();
      end
      conv_rdy = 1'b1;
      total++; if (conv_vld !== 1'b1) begin bad++; $display("FAIL cfg_before_hs got=%b want=1", conv_vld); end
      tick();
      conv_rdy = 1'b0;
      total++; if (conv_vld !== 1'b0) begin bad++; $display("FAIL cfg_after_hs got=%b want=0", conv_vld); end
      #1;
      total++; if (m_tvld !== 1'b1) begin bad++; $display("FAIL cfg_stream_start got=%b want=1", m_tvld); end
   endtask

   task automatic test_trdy_toggle();
      logic [DW-1:0] bd [4];
      logic [KW-1:0] bk [4];
      int idx;
      do_reset();
      for (int b = 0; b < 4; b++) begin bd[b] = rnd_data(); bk[b] = rnd_keep(); end
      bk[2] = '0;
      cmd_vld = 4'b0010;
      tick();
      cmd_vld = '0;
      conv_rdy = 1'b1;
      tick();
      conv_rdy = 1'b0;
      idx = 0;
      for (int cyc = 0; cyc < 12 && idx < 4; cyc++) begin
         m_trdy = (cyc % 2 == 0);
         set_beat(1, bd[idx], bk[idx], (idx == 3), 1'b1);
         set_beat(0, rnd_data(), rnd_keep(), 1'b1, 1'b1);
         set_beat(2, rnd_data(), rnd_keep(), 1'b1, 1'b1);
         set_beat(3, rnd_data(), rnd_keep(), 1'b1, 1'b1);
         #1;
         total++; if (s_trdy !== {2'b00, m_trdy, 1'b0}) begin bad++; $display("FAIL toggle_trdy beat=%0d got=%b want=00%b0", idx, s_trdy, m_trdy); end
         total++; if (m_tvld !== 1'b1 || m_tdata !== bd[idx] || m_tkeep !== bk[idx] || m_tlast !== (idx == 3)) begin bad++; $display("FAIL toggle_beat beat=%0d got vld=%b last=%b keep=%h want 1 %b %h", idx, m_tvld, m_tlast, m_tkeep, (idx == 3), bk[idx]); end
         if (m_trdy) idx++;
         tick();
      end
      m_trdy = 1'b1;
      set_beat(1, rnd_data(), '1, 1'b1, 1'b1);
      #1;
      total++; if (s_trdy !== '0 || m_tvld !== 1'b0) begin bad++; $display("FAIL toggle_extra_beat got trdy=%b vld=%b want=0000/0", s_trdy, m_tvld); end
      out_last = 1'b1;
      tick();
      out_last = 1'b0;
      total++; if (done !== 4'b0010 || grant !== '0) begin bad++; $display("FAIL toggle_done got done=%b grant=%b want=0010/0000", done, grant); end
   endtask

   task automatic test_early_out_last();
      logic [DW-1:0] d0;
      do_reset();
      cmd_vld = 4'b1000;
      tick();
      cmd_vld = '0;
      conv_rdy = 1'b1;
      tick();
      conv_rdy = 1'b0;
      d0 = rnd_data();
      set_beat(3, d0, '1, 1'b0, 1'b1);
      m_trdy = 1'b1;
      out_last = 1'b1;
      #1;
      total++; if (m_tdata !== d0 || m_tvld !== 1'b1) begin bad++; $display("FAIL early_beat0 got vld=%b want=1 with data", m_tvld); end
      tick();
      out_last = 1'b0;
      set_beat(3, rnd_data(), rnd_keep(), 1'b1, 1'b1);
      #1;
      total++; if (m_tlast !== 1'b1) begin bad++; $display("FAIL early_tlast got=%b want=1", m_tlast); end
      tick();
      set_beat(3, '0, '0, 1'b0, 1'b0);
      total++; if (done !== 4'b1000 || grant !== '0) begin bad++; $display("FAIL early_done got done=%b grant=%b want=1000/0000", done, grant); end
      cmd_vld = 4'b0001;
      #1;
      total++; if (cmd_rdy !== 4'b0001) begin bad++; $display("FAIL early_idle_accept got=%b want=0001", cmd_rdy); end
      tick();
      cmd_vld = '0;
      total++; if (grant !== 4'b0001 || done !== '0) begin bad++; $display("FAIL early_next_grant got grant=%b done=%b want=0001/0000", grant, done); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      cmd_vld = 4'b0100;
      tick();
      cmd_vld = '0;
      conv_rdy = 1'b1;
      tick();
      conv_rdy = 1'b0;
      set_beat(2, rnd_data(), '1, 1'b0, 1'b1);
      m_trdy = 1'b1;
      #1;
      total++; if (s_trdy !== 4'b0100) begin bad++; $display("FAIL rstmid_trdy_before got=%b want=0100", s_trdy); end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (grant !== '0 || done !== '0 || conv_vld !== 1'b0) begin bad++; $display("FAIL rstmid_regs got grant=%b done=%b cvld=%b want=0", grant, done, conv_vld); end
      #1;
      total++; if (s_trdy !== '0 || m_tvld !== 1'b0) begin bad++; $display("FAIL rstmid_stream got trdy=%b vld=%b want=0", s_trdy, m_tvld); end
      out_last = 1'b1;
      tick();
      out_last = 1'b0;
      total++; if (done !== '0) begin bad++; $display("FAIL rstmid_no_done got=%b want=0", done); end
      cmd_vld = 4'b1001;
      #1;
      total++; if (cmd_rdy !== 4'b0001) begin bad++; $display("FAIL rstmid_ch0_first got=%b want=0001", cmd_rdy); end
      tick();
      cmd_vld = '0;
   endtask

   // Transaction-level model: one transfer at a time; a transfer is granted by
   // round robin, configured, streamed until its input tlast, and completes once
   // both the input tlast and a converter output-last have been seen.
   task automatic test_round_robin(input bit rnd_mode, input int n_cyc, input int n_done);
      int            ph, owner, last_g, k, ol_cnt, completed;
      logic          seen, tl, acc;
      logic [CH-1:0] done_e, exp_g, exp_rdy, exp_trdy;
      logic [OW-1:0] se, me;
      int            bcnt [CH];
      int            nb   [CH];
      logic [DW-1:0] dat  [CH];
      logic [KW-1:0] kp   [CH];
      logic          e_vld, e_last;
      logic [DW-1:0] e_d;
      logic [KW-1:0] e_k;
      do_reset();
      ph = 0; owner = 0; last_g = CH - 1; seen = 1'b0; done_e = '0;
      se = '0; me = '0; ol_cnt = 0; completed = 0;
      for (int i = 0; i < CH; i++) begin bcnt[i] = 0; nb[i] = 1; end
      for (int cyc = 0; cyc < n_cyc && completed < n_done; cyc++) begin
         tick();
         exp_g = (ph != 0) ? oh(owner) : '0;
         total++; if (grant !== exp_g) begin bad++; $display("FAIL rr_grant cyc=%0d got=%b want=%b", cyc, grant, exp_g); end
         total++; if (done !== done_e) begin bad++; $display("FAIL rr_done cyc=%0d got=%b want=%b", cyc, done, done_e); end
         if (done_e != '0) completed++;
         total++; if (conv_vld !== (ph == 1)) begin bad++; $display("FAIL rr_conv_vld cyc=%0d got=%b want=%b", cyc, conv_vld, (ph == 1)); end
         if (ph == 1) begin
            total++; if (s_ofs !== se || m_ofs !== me) begin bad++; $display("FAIL rr_ofs cyc=%0d got=%h/%h want=%h/%h", cyc, s_ofs, m_ofs, se, me); end
         end
         cmd_vld = rnd_mode ? CH'($urandom) : {CH{1'b1}};
         for (int c = 0; c < CH; c++) begin
            saddr[c*AW +: AW] = $urandom;
            daddr[c*AW +: AW] = $urandom;
            dat[c] = rnd_data();
            kp[c]  = ($urandom_range(0, 3) == 0) ? '0 : rnd_keep();
            tl     = (ph == 2 && c == owner) ? (bcnt[c] == nb[c] - 1) : 1'($urandom);
            set_beat(c, dat[c], kp[c], tl, rnd_mode ? 1'($urandom) : 1'b1);
         end
         conv_rdy = rnd_mode ? 1'($urandom) : 1'b1;
         m_trdy   = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (rnd_mode) out_last = ($urandom_range(0, 4) == 0);
         else begin
            out_last = 1'b0;
            if (ol_cnt > 0) begin ol_cnt--; out_last = (ol_cnt == 0); end
         end
         #1;
         k = (ph == 0) ? pick(cmd_vld, last_g) : -1;
         exp_rdy = (k >= 0) ? oh(k) : '0;
         exp_trdy = '0; e_vld = 1'b0; e_last = 1'b0; e_d = '0; e_k = '0;
         if (ph == 2) begin
            exp_trdy = m_trdy ? oh(owner) : '0;
            e_vld = s_tvld[owner]; e_last = s_tlast[owner]; e_d = dat[owner]; e_k = kp[owner];
         end
         total++; if (cmd_rdy !== exp_rdy) begin bad++; $display("FAIL rr_cmd_rdy cyc=%0d got=%b want=%b", cyc, cmd_rdy, exp_rdy); end
         total++; if (s_trdy !== exp_trdy) begin bad++; $display("FAIL rr_s_trdy cyc=%0d got=%b want=%b", cyc, s_trdy, exp_trdy); end
         total++; if (m_tvld !== e_vld || m_tlast !== e_last) begin bad++; $display("FAIL rr_m_ctl cyc=%0d got=%b%b want=%b%b", cyc, m_tvld, m_tlast, e_vld, e_last); end
         total++; if (m_tdata !== e_d || m_tkeep !== e_k) begin bad++; $display("FAIL rr_m_data cyc=%0d got keep=%h want keep=%h", cyc, m_tkeep, e_k); end
         done_e = '0;
         acc = (ph == 2) && s_tvld[owner] && m_trdy;
         case (ph)
            0: if (k >= 0) begin
               owner = k; last_g = k; ph = 1; seen = 1'b0;
               se = saddr[k*AW +: OW]; me = daddr[k*AW +: OW];
               bcnt[k] = 0; nb[k] = rnd_mode ? $urandom_range(1, 4) : 3;
            end
            1: begin
               if (out_last) seen = 1'b1;
               if (conv_rdy) ph = 2;
            end
            2: begin
               if (acc) bcnt[owner]++;
               if (acc && s_tlast[owner]) begin
                  if (seen || out_last) begin ph = 0; done_e = oh(owner); seen = 1'b0; end
                  else begin ph = 3; ol_cnt = 2; end
               end else if (out_last) seen = 1'b1;
            end
            default: if (out_last) begin ph = 0; done_e = oh(owner); end
         endcase
      end
      if (!rnd_mode) begin
         total++; if (completed < n_done) begin bad++; $display("FAIL rr_timeout got=%0d completions want=%0d", completed, n_done); end
      end
   endtask

   initial begin
      rst = 1'b1;
      clr_inputs();
      test_reset();
      test_ch2_cmd();
      test_cfg_stall();
      test_trdy_toggle();
      test_early_out_last();
      test_reset_mid();
      test_round_robin(1'b0, 200, 5);
      test_round_robin(1'b1, 800, 1000000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/str_ofs_conv_sched.md
Name: str_ofs_conv_sched

Overview:
- Round-robin scheduler that shares one byte-offset stream converter among CH_NUM DMA channels.
- Accepts one command (source/destination address) per channel and derives the converter's s_ofs/m_ofs from the address low bits.
- Runs the converter's config handshake, muxes the granted channel's AXI-Stream into the converter until tlast, then holds the grant until the converter reports its output tlast.
- Sits between the channel DMA engines and the converter input.

Parameters:
DATA_WIDTH, 512, stream data width in bits
BYTE_WIDTH, 8, bits per byte lane
CH_NUM, 4, number of requesting channels (2..16)
ADDR_WIDTH, 32, command address width
OFS_W (local), $clog2(DATA_WIDTH/BYTE_WIDTH), offset width; 6 at defaults

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_cmd_vld  in  CH_NUM  per-channel command valid
o_cmd_rdy  out  CH_NUM  per-channel command accept (one-hot or zero)
i_cmd_saddr  in  CH_NUM*ADDR_WIDTH  source byte address; ch k at [k*ADDR_WIDTH +: ADDR_WIDTH]
i_cmd_daddr  in  CH_NUM*ADDR_WIDTH  destination byte address
s_axis_tdata  in  CH_NUM*DATA_WIDTH  channel stream data
s_axis_tkeep  in  CH_NUM*DATA_WIDTH/BYTE_WIDTH  channel byte enables
s_axis_tlast  in  CH_NUM  channel last
s_axis_tvld  in  CH_NUM  channel valid
s_axis_trdy  out  CH_NUM  channel ready
o_conv_vld  out  1  converter config valid
i_conv_rdy  in  1  converter config ready
o_conv_s_ofs  out  OFS_W  source offset
o_conv_m_ofs  out  OFS_W  destination offset
m_axis_tdata  out  DATA_WIDTH  to converter
m_axis_tkeep  out  DATA_WIDTH/BYTE_WIDTH  to converter
m_axis_tlast  out  1  to converter
m_axis_tvld  out  1  to converter
m_axis_trdy  in  1  from converter
i_out_last  in  1  one-cycle pulse: converter output beat with tlast accepted downstream
o_grant  out  CH_NUM  one-hot granted channel; 0 when idle
o_done  out  CH_NUM  one-cycle pulse on channel completion

Behaviour:
- Reset (sync, i_rst=1 at posedge):
  - state=IDLE; o_grant=0, o_conv_vld=0, o_conv_s_ofs=0, o_conv_m_ofs=0, o_done=0.
  - rr pointer = CH_NUM-1, so ch0 has first priority; out_last_seen flag=0.
  - Combinational outputs are 0 while in IDLE with no request.
  - Reset mid-operation abandons the transfer: no o_done, converter stream is dropped. The system resets the converter together with this block.
- FSM states: IDLE, CFG, STRM, DRAIN.
- IDLE:
  - Requesting channel = first k with i_cmd_vld[k]=1, searching from ptr+1 upward with wrap.
  - Same cycle, combinational: o_cmd_rdy[k]=1.
  - Registered into next cycle: o_grant=onehot(k); s_ofs=saddr_k[OFS_W-1:0]; m_ofs=daddr_k[OFS_W-1:0]; ptr=k; o_conv_vld=1; state->CFG.
  - No request: stay in IDLE.
- CFG:
  - o_conv_vld held with offsets stable until i_conv_rdy=1.
  - On handshake: o_conv_vld=0 next cycle, state->STRM.
  - Minimum latency cmd accept -> first stream beat possible: 2 cycles.
- STRM (zero-latency combinational mux, g = granted channel):
  - m_axis_* = s_axis_* of g.
  - s_axis_trdy[g]=m_axis_trdy; all other s_axis_trdy=0.
  - On an accepted beat with tlast (tvld&trdy&tlast): next state = DRAIN, or IDLE if out_last_seen (or i_out_last this cycle).
  - Outside STRM: m_axis_tvld=0, m_axis_tlast=0, all s_axis_trdy=0; data/keep are don't-care, driven 0.
- DRAIN:
  - Wait for i_out_last; then state->IDLE, o_grant=0, o_done[g]=1 for one cycle.
  - The IDLE arrival cycle can accept a new command (back-to-back arbitration, no bubble besides DRAIN).
- i_out_last outside DRAIN:
  - In CFG or STRM it sets out_last_seen. Completion then happens directly at the STRM exit: o_done pulses on that transition and the flag is cleared.
  - In IDLE it is ignored.
- Arbitration and command handling:
  - Only one command outstanding at a time; o_cmd_rdy stays 0 outside IDLE.
  - Fairness: with all channels requesting continuously, grants cycle 0,1,2,3,0,…
  - A channel deasserting i_cmd_vld before grant loses nothing; commands are not latched until o_cmd_rdy.
  - Single-beat stream (first beat carries tlast) is legal.
  - tkeep is passed unchanged; zero-keep beats are forwarded as-is.

Test Plan:
- Reset then ch2 only: saddr=0x1005, daddr=0x2030 -> o_cmd_rdy[2] pulses; next cycle o_conv_vld=1, s_ofs=5, m_ofs=0x30, o_grant=4'b0100.
- All four channels request continuously, 3-beat streams, i_out_last 2 cycles after input tlast -> grant order 0,1,2,3,0; o_done pulses in that order; no s_axis_trdy asserted on ungranted channels.
- Converter holds i_conv_rdy=0 for 5 cycles -> o_conv_vld and offsets stable throughout; no m_axis_tvld until after handshake.
- m_axis_trdy toggling 1,0,1,0 during STRM on ch1 -> s_axis_trdy[1] mirrors it; exactly the 4 source beats appear on m_axis, last with tlast=1.
- i_out_last pulsed during STRM before input tlast -> on the input tlast beat, o_done pulses in the same transition and FSM goes straight to IDLE (skips DRAIN).
- i_rst asserted in STRM mid-packet -> next cycle o_grant=0, all trdy=0, no o_done; a following ch0 request is granted first.
